pc_next_unit: RTL

//  Registered program-counter stage for the MIPS datapath. Replaces the plain next-PC selector.

---
 rtl/pc_next_if.sv | 26 ++
 rtl/pc_next_unit.sv | 64 ++++++
 2 files changed

// File: rtl/pc_next_if.sv
// pc_next_if: fetch-side bundle between control/branch logic and the PC stage; exc_in/epc_out exist only with PC_EXC_EN
interface pc_next_if #(parameter int WIDTH = 32);
  logic [1:0] sel;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] reg_tgt;
  logic fetch_ready;
  logic halt_req;
  logic resume;
  logic [WIDTH-1:0] pc_out;
  logic pc_valid;
  logic align_err;
`ifdef PC_EXC_EN
  logic exc_in;
  logic [WIDTH-1:0] epc_out;
  modport master(output sel, branch_tgt, jump_tgt, reg_tgt, fetch_ready, halt_req, resume, exc_in,
                 input pc_out, pc_valid, align_err, epc_out);
  modport slave(input sel, branch_tgt, jump_tgt, reg_tgt, fetch_ready, halt_req, resume, exc_in,
                output pc_out, pc_valid, align_err, epc_out);
`else
  modport master(output sel, branch_tgt, jump_tgt, reg_tgt, fetch_ready, halt_req, resume,
                 input pc_out, pc_valid, align_err);
  modport slave(input sel, branch_tgt, jump_tgt, reg_tgt, fetch_ready, halt_req, resume,
                output pc_out, pc_valid, align_err);
`endif
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered MIPS PC with branch/jump/jr redirects and BOOT/RUN/HALT control
// Define PC_EXC_EN to add exception entry (exc_in, epc_out, EXC_VECTOR).
module pc_next_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_EXC_EN
  , parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'('h80)
`endif
) (
  input logic clk,
  input logic rst_n,
  pc_next_if.slave bus
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam logic [WIDTH-1:0] INC = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(STEP - 1);
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] tgt;
  logic run, accept, redirect, exc;
  assign run = state == RUN;
  assign accept = bus.pc_valid & bus.fetch_ready;
  assign redirect = run & (bus.sel != 2'b00);
`ifdef PC_EXC_EN
  assign exc = bus.exc_in & (state != BOOT);
`else
  assign exc = 1'b0;
`endif
  always_comb begin
    tgt = bus.sel == 2'b01 ? bus.branch_tgt : bus.sel == 2'b10 ? bus.jump_tgt : bus.reg_tgt;
    state_nxt = (state == BOOT || exc) ? RUN :
                run ? (bus.halt_req ? HALT : RUN) :
                (bus.resume & ~bus.halt_req) ? RUN : HALT;
  end
  // pc_valid is its own flop so the fetch request never depends on this cycle's inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      bus.pc_out <= RESET_VECTOR;
      bus.pc_valid <= 1'b0;
      bus.align_err <= 1'b0;
`ifdef PC_EXC_EN
      bus.epc_out <= '0;
`endif
    end else begin
      state <= state_nxt;
      bus.pc_valid <= state_nxt == RUN;
      bus.align_err <= 1'b0;
`ifdef PC_EXC_EN
      if (exc) begin
        bus.epc_out <= bus.pc_out;
        bus.pc_out <= EXC_VECTOR;
      end else
`endif
      if (redirect) begin
        bus.pc_out <= tgt & ~MASK;
        bus.align_err <= |(tgt & MASK);
      end else if (accept)
        bus.pc_out <= bus.pc_out + INC;
    end
  end
endmodule
